axi_axis_writer: RTL and testbench
==================================

Name: axi_axis_writer

Overview:
- AXI4-Lite slave that feeds an AXI4-Stream master: each CPU write to the DATA register pushes one word into an internal FIFO, and the FIFO drains onto m_axis.
- It is the transmit-side counterpart of the AXIS-to-AXI-Lite reader. It sits between the PS register bus and PL stream consumers, for example DAC or test-pattern sinks.
- Status and control registers expose FIFO level, overflow and flush.

Parameters:
- AXI_ADDR_WIDTH, 12, width of the AXI-Lite address; only bits [3:2] are decoded.
- AXI_DATA_WIDTH, 32, AXI-Lite data width; fixed at 32.
- AXIS_DATA_WIDTH, 24, m_axis_tdata width; must be ≤ AXI_DATA_WIDTH.
- FIFO_DEPTH, 16, number of FIFO entries; a power of 2, minimum 2.

Ports:
- aclk  in  1  system clock; all logic is on the rising edge.
- areset  in  1  asynchronous active-high reset.
- s_axi_awaddr  in  AXI_ADDR_WIDTH  write address.
- s_axi_awvalid / s_axi_awready  in/out  1  write-address handshake.
- s_axi_wdata  in  AXI_DATA_WIDTH  write data; s_axi_wstrb is not implemented and writes are full-word.
- s_axi_wvalid / s_axi_wready  in/out  1  write-data handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out/in  1  write-response handshake.
- s_axi_araddr  in  AXI_ADDR_WIDTH  read address.
- s_axi_arvalid / s_axi_arready  in/out  1  read-address handshake.
- s_axi_rdata  out  AXI_DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid / s_axi_rready  out/in  1  read-data handshake.
- m_axis_tdata  out  AXIS_DATA_WIDTH  stream data.
- m_axis_tvalid / m_axis_tready  out/in  1  stream handshake.

Behaviour:
- Reset: asynchronous on areset=1. All outputs return to 0: awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp, m_axis_tvalid, m_axis_tdata. FIFO is emptied (count=0) and the overflow flag is cleared.
  - Reset mid-transaction aborts the transaction; no response is issued.
  - A word that was presented but not yet accepted on m_axis is lost.
- Register map (byte offset, decode on addr[3:2]):
  - 0x0 DATA (W): pushes wdata[AXIS_DATA_WIDTH-1:0]; upper bits are ignored. Reads return 0.
  - 0x4 STATUS (R): bit0 empty, bit1 full, bit2 overflow (sticky), bits[15:8] count. Writes are ignored.
  - 0x8 CONTROL (W): bit0 flush, bit1 clear overflow; both are self-clearing pulses. Reads return 0.
  - 0xC: reserved; reads return 0, writes are ignored, response OKAY.
- Write channel:
  - awready and wready are independent: each is high while its address/data latch is empty and bvalid=0.
  - The AW and W beats may arrive in either order or in the same cycle.
  - The write executes in the cycle after both latches are full. bvalid rises that same cycle and holds until bready.
  - Latches free on the bvalid&bready cycle. One outstanding write at a time.
- bresp:
  - 2'b00 OKAY normally.
  - 2'b10 SLVERR for a DATA write that finds the FIFO full with no pop in the same cycle. In that case the word is dropped and overflow is set.
- Read channel:
  - arready=1 when rvalid=0 and no read is pending.
  - rdata/rresp are registered; rvalid rises 1 cycle after the AR handshake and holds until rready.
  - rresp is always 00. STATUS is sampled at the AR handshake cycle.
- Stream side:
  - m_axis_tvalid = !empty; m_axis_tdata = FIFO head, registered and FWFT.
  - Pop on tvalid&tready.
  - tdata must not change while tvalid=1 and tready=0.
- FIFO boundaries:
  - Simultaneous push and pop when full: push accepted, count unchanged, OKAY.
  - Simultaneous push and pop when count=1: the next head is the pushed word, and tvalid stays 1.
  - Pointers wrap modulo FIFO_DEPTH. count width is clog2(FIFO_DEPTH)+1, which is reported zero-extended in STATUS.
  - No combinational path from tready to any AXI-Lite output.
- Control writes:
  - Flush empties the FIFO in the execute cycle and wins over a same-cycle pop. tvalid is 0 the following cycle.
  - Clear overflow clears the sticky flag. If an overflow occurs in the same cycle, the set wins.

Decomposition:
- Shared package axi_axis_pkg contains:
  - register offset constants ADDR_DATA, ADDR_STATUS, ADDR_CONTROL;
  - STATUS bit indices;
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- One sub-module, axis_sync_fifo:
  - parameters WIDTH and DEPTH;
  - ports push, din, pop, flush, dout, empty, full, count;
  - async active-high reset.
- The top level holds the AXI-Lite FSMs, register decode and overflow logic.

Test Plan:
- Reset, then write DATA=0x000000FF with m_axis_tready=1 -> bresp=00; m_axis_tvalid for exactly one cycle with tdata=24'h0000FF; STATUS reads 0x00000001.
- tready=0, write 16 words 1..16, then a 17th word 0x11 -> first 16 writes bresp=00; 17th bresp=10; STATUS=0x00001006 (count=16, full, overflow); then raise tready -> tdata 1..16 in order, and 0x11 never appears.
- AW presented 3 cycles before W, then W presented before AW, with bready held 0 for 4 cycles -> each write executes exactly once; bvalid is held until bready; awready=0 while bvalid=1.
- FIFO full with tready=1 and a DATA write of 0xABCDEF in the same cycle -> bresp=00; count stays 16; 0xABCDEF emerges last; overflow stays 0.
- 5 words queued, tready=0, write CONTROL=0x1 -> the next cycle tvalid=0 and STATUS=0x00000001; then write CONTROL=0x2 after an overflow -> overflow bit reads 0.
- Assert areset while tvalid=1 and tready=0, and again while bvalid=1 -> all outputs 0 immediately (asynchronously); FIFO empty after release.

Source files
------------

// File: rtl/axi_axis_pkg.sv
// Shared definitions for the AXI-Lite to AXI-Stream writer: register map,
// STATUS/CONTROL bit positions, response codes and channel state types.
package axi_axis_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_CONTROL = 2'd2;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    localparam int CTRL_FLUSH   = 0;
    localparam int CTRL_CLR_OVF = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {WR_COLLECT, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    function automatic logic [31:0] pack_status(input logic       empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [7:0] count);
        logic [31:0] s;
        s                     = '0;
        s[STAT_EMPTY]         = empty;
        s[STAT_FULL]          = full;
        s[STAT_OVF]           = ovf;
        s[STAT_CNT_LSB +: 8]  = count;
        return s;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head output,
// synchronous flush and push-while-full allowed when a pop happens alongside.
module axis_sync_fifo #(
    parameter  int WIDTH = 24,
    parameter  int DEPTH = 16,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] r_dout;
    logic             w_push_eff;
    logic             w_pop_eff;

    assign empty        = (r_count == '0);
    assign full         = (r_count == FULL_CNT);
    assign count        = r_count;
    assign dout         = r_dout;
    assign w_pop_eff    = pop && !empty;
    assign w_push_eff   = push && (!full || w_pop_eff);
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (w_push_eff && !flush) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_eff) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_eff) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push_eff, w_pop_eff})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head register: the next entry comes from memory unless the FIFO is
    // (about to be) empty, in which case the incoming word bypasses memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout <= '0;
        end else if (!flush) begin
            if (w_pop_eff && (r_count != ONE_CNT)) begin
                r_dout <= r_mem[w_rd_ptr_nxt];
            end else if ((w_pop_eff || empty) && w_push_eff) begin
                r_dout <= din;
            end
        end
    end

endmodule

// File: rtl/axi_axis_writer.sv
// AXI4-Lite slave whose DATA register pushes words into a FIFO drained onto an
// AXI4-Stream master; STATUS/CONTROL expose level, sticky overflow and flush.
module axi_axis_writer
    import axi_axis_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 12,
    parameter int AXI_DATA_WIDTH  = 32,
    parameter int AXIS_DATA_WIDTH = 24,
    parameter int FIFO_DEPTH      = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]  s_axi_wdata,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready,
    output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    wr_state_t                  r_wr_state;
    wr_state_t                  w_wr_state_nxt;
    rd_state_t                  r_rd_state;
    rd_state_t                  w_rd_state_nxt;
    logic                       r_run;
    logic                       r_aw_full;
    logic                       r_w_full;
    logic [AXI_ADDR_WIDTH-1:0]  r_awaddr;
    logic [AXI_DATA_WIDTH-1:0]  r_wdata;
    logic [1:0]                 r_bresp;
    logic [AXI_DATA_WIDTH-1:0]  r_rdata;
    logic                       r_ovf;

    logic                       w_aw_hs;
    logic                       w_w_hs;
    logic                       w_b_hs;
    logic                       w_ar_hs;
    logic                       w_exec;
    logic [1:0]                 w_wr_sel;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_flush;
    logic                       w_clr_ovf;
    logic                       w_ovf_set;
    logic                       w_empty;
    logic                       w_full;
    logic [CNT_W-1:0]           w_count;
    logic                       w_unused;

    // Ready outputs stay low until the first clock after reset release so
    // that every output reads 0 for as long as areset is asserted.
    assign s_axi_awready = r_run && (r_wr_state == WR_COLLECT) && !r_aw_full;
    assign s_axi_wready  = r_run && (r_wr_state == WR_COLLECT) && !r_w_full;
    assign s_axi_bvalid  = (r_wr_state == WR_RESP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_run && (r_rd_state == RD_IDLE);
    assign s_axi_rvalid  = (r_rd_state == RD_DATA);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = RESP_OKAY;
    assign m_axis_tvalid = !w_empty;

    assign w_aw_hs   = s_axi_awvalid && s_axi_awready;
    assign w_w_hs    = s_axi_wvalid && s_axi_wready;
    assign w_b_hs    = s_axi_bvalid && s_axi_bready;
    assign w_ar_hs   = s_axi_arvalid && s_axi_arready;
    assign w_wr_sel  = r_awaddr[3:2];
    assign w_push    = w_exec && (w_wr_sel == ADDR_DATA);
    assign w_pop     = m_axis_tvalid && m_axis_tready;
    assign w_flush   = w_exec && (w_wr_sel == ADDR_CONTROL) && r_wdata[CTRL_FLUSH];
    assign w_clr_ovf = w_exec && (w_wr_sel == ADDR_CONTROL) && r_wdata[CTRL_CLR_OVF];
    assign w_ovf_set = w_push && w_full && !w_pop;
    assign w_unused  = ^{r_awaddr, r_wdata, s_axi_araddr};

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_wr_state <= WR_COLLECT;
            r_rd_state <= RD_IDLE;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_rd_state <= w_rd_state_nxt;
        end
    end

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_exec         = 1'b0;
        case (r_wr_state)
            WR_COLLECT: begin
                if (r_aw_full && r_w_full) begin
                    w_exec         = 1'b1;
                    w_wr_state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (s_axi_bready) begin
                    w_wr_state_nxt = WR_COLLECT;
                end
            end
            default: w_wr_state_nxt = WR_COLLECT;
        endcase
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        case (r_rd_state)
            RD_IDLE: begin
                if (w_ar_hs) begin
                    w_rd_state_nxt = RD_DATA;
                end
            end
            RD_DATA: begin
                if (s_axi_rready) begin
                    w_rd_state_nxt = RD_IDLE;
                end
            end
            default: w_rd_state_nxt = RD_IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else if (w_b_hs) begin
            r_aw_full <= 1'b0;
            r_w_full  <= 1'b0;
        end else begin
            if (w_aw_hs) begin
                r_aw_full <= 1'b1;
            end
            if (w_w_hs) begin
                r_w_full <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (w_aw_hs) begin
            r_awaddr <= s_axi_awaddr;
        end
        if (w_w_hs) begin
            r_wdata <= s_axi_wdata;
        end
    end

    // A same-cycle overflow beats a clear request so no drop goes unreported.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_ovf   <= 1'b0;
            r_bresp <= RESP_OKAY;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_exec) begin
                r_bresp <= w_ovf_set ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_rdata <= '0;
        end else if (w_ar_hs) begin
            if (s_axi_araddr[3:2] == ADDR_STATUS) begin
                r_rdata <= pack_status(w_empty, w_full, r_ovf, 8'(w_count));
            end else begin
                r_rdata <= '0;
            end
        end
    end

    axis_sync_fifo #(
        .WIDTH (AXIS_DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (w_push),
        .din   (r_wdata[AXIS_DATA_WIDTH-1:0]),
        .pop   (w_pop),
        .flush (w_flush),
        .dout  (m_axis_tdata),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

endmodule

// File: tb/tb_axi_axis_writer.sv
// Directed bench for axi_axis_writer: register writes/reads over AXI-Lite and
// a stream monitor collecting every accepted m_axis beat.
module tb_axi_axis_writer;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [11:0] s_axi_awaddr = '0;
    logic        s_axi_awvalid = 1'b0;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata = '0;
    logic        s_axi_wvalid = 1'b0;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready = 1'b0;
    logic [11:0] s_axi_araddr = '0;
    logic        s_axi_arvalid = 1'b0;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready = 1'b0;
    logic [23:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] got_q[$];

    always #5 aclk = ~aclk;

    axi_axis_writer dut (
        .aclk          (aclk),
        .areset        (areset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready)
    );

    always @(negedge aclk) begin
        #1;
        if (!areset && m_axis_tvalid && m_axis_tready) begin
            got_q.push_back(32'(m_axis_tdata));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic any_out();
        return |{s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_bresp, s_axi_arready,
                 s_axi_rvalid, s_axi_rdata, s_axi_rresp, m_axis_tvalid, m_axis_tdata};
    endfunction

    function automatic logic [31:0] q_at(input int idx);
        if (idx < got_q.size()) return got_q[idx];
        return 32'hDEAD_BEEF;
    endfunction

    // Called on a falling edge; AW/W are raised aw_dly/w_dly cycles in, and
    // bready is withheld for bhold cycles once bvalid appears.
    task automatic axi_wr_skew(input logic [11:0] a, input logic [31:0] d, input int aw_dly,
                               input int w_dly, input int bhold, output logic [1:0] resp);
        int t;
        bit aw_done, w_done, aw_hs, w_hs, held_ok;
        t = 0; aw_done = 0; w_done = 0; held_ok = 1;
        s_axi_awaddr = a;
        s_axi_wdata  = d;
        s_axi_bready = 1'b0;
        while (!(aw_done && w_done) && t < 100) begin
            s_axi_awvalid = !aw_done && (t >= aw_dly);
            s_axi_wvalid  = !w_done && (t >= w_dly);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(negedge aclk);
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            t++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (t >= 100) check_eq("wr_addr_data_timeout", 32'(t), 32'd0);
        t = 0;
        while (!s_axi_bvalid && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 100) check_eq("wr_bvalid_timeout", 32'(t), 32'd0);
        resp = s_axi_bresp;
        repeat (bhold) begin
            @(negedge aclk);
            if (!s_axi_bvalid || s_axi_awready || s_axi_wready) held_ok = 0;
        end
        if (bhold > 0) check_eq("b_hold_no_ready", 32'(held_ok), 32'd1);
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_wr(input logic [11:0] a, input logic [31:0] d, output logic [1:0] resp);
        axi_wr_skew(a, d, 0, 0, 0, resp);
    endtask

    task automatic axi_rd(input logic [11:0] a, output logic [31:0] d);
        int t;
        t = 0;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = 1'b1;
        while (!s_axi_arready && t < 100) begin
            @(negedge aclk);
            t++;
        end
        @(negedge aclk);
        s_axi_arvalid = 1'b0;
        while (!s_axi_rvalid && t < 100) begin
            @(negedge aclk);
            t++;
        end
        if (t >= 100) check_eq("rd_timeout", 32'(t), 32'd0);
        d = s_axi_rdata;
        @(negedge aclk);
        s_axi_rready = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        m_axis_tready = 1'b1;
        while (m_axis_tvalid && t < 200) begin
            @(negedge aclk);
            t++;
        end
        m_axis_tready = 1'b0;
        check_eq("drain_done", 32'(m_axis_tvalid), 32'd0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rd;
        int          t;

        // Reset state
        repeat (3) @(negedge aclk);
        check_eq("reset_outputs_zero", 32'(any_out()), 32'd0);
        areset = 1'b0;
        @(negedge aclk);

        // Single word passes straight through
        m_axis_tready = 1'b1;
        got_q.delete();
        axi_wr(12'h000, 32'h0000_00FF, resp);
        check_eq("t1_bresp", 32'(resp), 32'd0);
        repeat (3) @(negedge aclk);
        check_eq("t1_beats", 32'(got_q.size()), 32'd1);
        check_eq("t1_tdata", q_at(0), 32'h0000_00FF);
        axi_rd(12'h004, rd);
        check_eq("t1_status", rd, 32'h0000_0001);

        // Fill to full, then overflow
        m_axis_tready = 1'b0;
        got_q.delete();
        for (int i = 1; i <= 16; i++) begin
            axi_wr(12'h000, 32'(i), resp);
            check_eq("t2_fill_bresp", 32'(resp), 32'd0);
        end
        axi_wr(12'h000, 32'h0000_0011, resp);
        check_eq("t2_ovf_bresp", 32'(resp), 32'd2);
        check_eq("t2_head_held", 32'(m_axis_tdata), 32'd1);
        axi_rd(12'h004, rd);
        check_eq("t2_status", rd, 32'h0000_1006);
        drain();
        check_eq("t2_beats", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check_eq("t2_order", q_at(i), 32'(i + 1));
        end

        // Clear sticky overflow
        axi_wr(12'h008, 32'h0000_0002, resp);
        check_eq("t5_clr_bresp", 32'(resp), 32'd0);
        axi_rd(12'h004, rd);
        check_eq("t5_clr_status", rd, 32'h0000_0001);

        // Skewed AW/W with delayed bready
        m_axis_tready = 1'b1;
        got_q.delete();
        axi_wr_skew(12'h000, 32'h0000_0021, 0, 3, 4, resp);
        check_eq("t3_aw_first_bresp", 32'(resp), 32'd0);
        axi_wr_skew(12'h000, 32'h0000_0022, 3, 0, 4, resp);
        check_eq("t3_w_first_bresp", 32'(resp), 32'd0);
        repeat (3) @(negedge aclk);
        check_eq("t3_bvalid_cleared", 32'(s_axi_bvalid), 32'd0);
        check_eq("t3_beats", 32'(got_q.size()), 32'd2);
        check_eq("t3_word0", q_at(0), 32'h0000_0021);
        check_eq("t3_word1", q_at(1), 32'h0000_0022);

        // Push while full with a simultaneous pop
        m_axis_tready = 1'b0;
        got_q.delete();
        for (int i = 0; i < 16; i++) begin
            axi_wr(12'h000, 32'(32'h31 + i), resp);
        end
        s_axi_awaddr  = 12'h000;
        s_axi_wdata   = 32'h00AB_CDEF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        check_eq("t4_ready_both", {30'd0, s_axi_awready, s_axi_wready}, 32'd3);
        @(negedge aclk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        m_axis_tready = 1'b0;
        check_eq("t4_bvalid", 32'(s_axi_bvalid), 32'd1);
        check_eq("t4_bresp", 32'(s_axi_bresp), 32'd0);
        s_axi_bready = 1'b1;
        @(negedge aclk);
        s_axi_bready = 1'b0;
        axi_rd(12'h004, rd);
        check_eq("t4_status_full_no_ovf", rd, 32'h0000_1002);
        drain();
        check_eq("t4_beats", 32'(got_q.size()), 32'd17);
        check_eq("t4_first", q_at(0), 32'h0000_0031);
        check_eq("t4_last", q_at(16), 32'h00AB_CDEF);

        // Flush
        for (int i = 0; i < 5; i++) begin
            axi_wr(12'h000, 32'(32'h51 + i), resp);
        end
        check_eq("t5_tvalid_before", 32'(m_axis_tvalid), 32'd1);
        axi_wr(12'h008, 32'h0000_0001, resp);
        check_eq("t5_flush_tvalid", 32'(m_axis_tvalid), 32'd0);
        axi_rd(12'h004, rd);
        check_eq("t5_flush_status", rd, 32'h0000_0001);

        // Asynchronous reset while a stream word is stalled
        axi_wr(12'h000, 32'h0000_0061, resp);
        check_eq("t6_stalled_tvalid", 32'(m_axis_tvalid), 32'd1);
        areset = 1'b1;
        #1;
        check_eq("t6_rst_stream_outs", 32'(any_out()), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        @(negedge aclk);
        axi_rd(12'h004, rd);
        check_eq("t6_status_after_rst", rd, 32'h0000_0001);

        // Asynchronous reset while a write response is pending
        s_axi_awaddr  = 12'h000;
        s_axi_wdata   = 32'h0000_0071;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = 1'b0;
        t = 0;
        while (!s_axi_bvalid && t < 50) begin
            @(negedge aclk);
            t++;
        end
        check_eq("t6_bvalid_pending", 32'(s_axi_bvalid), 32'd1);
        areset = 1'b1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        #1;
        check_eq("t6_rst_bvalid_outs", 32'(any_out()), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        repeat (3) @(negedge aclk);
        check_eq("t6_no_late_bvalid", 32'(s_axi_bvalid), 32'd0);
        axi_rd(12'h004, rd);
        check_eq("t6_status_after_rst2", rd, 32'h0000_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
